// File: rtl/cpu_apb_pkg.sv
// Shared types and widths for the CPU-side APB arbiter.
package cpu_apb_pkg;

  localparam int unsigned APB_ADDR_W = 16;
  localparam int unsigned APB_DATA_W = 16;
  localparam int unsigned REQ_F      = 0;
  localparam int unsigned REQ_D      = 1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_t;

  // Command latched at grant time and driven onto the APB for the whole transfer
  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational 2-way picker: round-robin on ties, or data-first when prio_d_i is set.
module apb_rr_pick
  import cpu_apb_pkg::*;
(
  input  logic [1:0] elig_i,
  input  logic       last_d_i,
  input  logic       prio_d_i,
  output logic [1:0] gnt_c_o
);

  always_comb begin
    gnt_c_o = 2'b00;
    if (elig_i[REQ_F] && elig_i[REQ_D]) begin
      if (prio_d_i || !last_d_i) begin
        gnt_c_o[REQ_D] = 1'b1;
      end else begin
        gnt_c_o[REQ_F] = 1'b1;
      end
    end else begin
      gnt_c_o = elig_i;
    end
  end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Shares one APB master between fetch (F) and data (D) requesters and owns SETUP/ACCESS.
// Optional ACCESS timeout with abort/err is enabled by defining APB_TIMEOUT_EN.
module apb_bus_arbiter
  import cpu_apb_pkg::*;
#(
  parameter int unsigned PRIO_MODE      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [APB_ADDR_W-1:0] f_addr,
  output logic                  f_done,
  output logic [APB_DATA_W-1:0] f_rdata,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [APB_ADDR_W-1:0] d_addr,
  input  logic [APB_DATA_W-1:0] d_wdata,
  output logic                  d_done,
  output logic [APB_DATA_W-1:0] d_rdata,
  output logic                  err,
  output logic [1:0]            gnt,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic                  pwrite,
  output logic [APB_DATA_W-1:0] pwdata,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready
);

  arb_state_t            state_q, state_d;
  apb_cmd_t              cmd_q, cmd_d;
  logic                  last_d_q, last_d_d;  // 1 = D owned the previous transfer
  logic                  psel_q, psel_d, penable_q, penable_d, busy_q, busy_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  f_done_q, f_done_d, d_done_q, d_done_d, err_q, err_d;
  logic [APB_DATA_W-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic [1:0]            elig_c, pick_c;
  logic                  accept_c, abort_c;

  // A requester still showing its done pulse may not have dropped req yet
  assign elig_c   = {d_req & ~d_done_q, f_req & ~f_done_q};
  assign accept_c = (state_q == ARB_ACCESS) && pready;

  apb_rr_pick u_pick (
    .elig_i   (elig_c),
    .last_d_i (last_d_q),
    .prio_d_i (PRIO_MODE != 0),
    .gnt_c_o  (pick_c)
  );

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed wait cycles; the limit cycle itself still honours pready
  assign abort_c = (state_q == ARB_ACCESS) && !pready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_d   = ((state_q == ARB_ACCESS) && !pready && !abort_c) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign abort_c        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    last_d_d  = last_d_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    busy_d    = busy_q;
    gnt_d     = gnt_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    f_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|pick_c) begin
          if (pick_c[REQ_D]) cmd_d = '{addr: d_addr, write: d_write, wdata: d_wdata};
          else               cmd_d = '{addr: f_addr, write: 1'b0, wdata: '0};
          psel_d    = 1'b1;
          penable_d = 1'b0;
          busy_d    = 1'b1;
          gnt_d     = pick_c;
          state_d   = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        penable_d = 1'b1;
        state_d   = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        if (accept_c || abort_c) begin
          f_done_d = gnt_q[REQ_F];
          d_done_d = gnt_q[REQ_D];
          err_d    = abort_c;
          if (abort_c) begin
            if (gnt_q[REQ_F]) f_rdata_d = '0;
            else              d_rdata_d = '0;
          end else if (!cmd_q.write) begin
            if (gnt_q[REQ_F]) f_rdata_d = prdata;
            else              d_rdata_d = prdata;
          end
          psel_d    = 1'b0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          gnt_d     = 2'b00;
          last_d_d  = gnt_q[REQ_D];
          state_d   = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      cmd_q     <= '0;
      last_d_q  <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      gnt_q     <= 2'b00;
      f_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      last_d_q  <= last_d_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      busy_q    <= busy_d;
      gnt_q     <= gnt_d;
      f_done_q  <= f_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign f_done  = f_done_q;
  assign d_done  = d_done_q;
  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign paddr   = cmd_q.addr;
  assign pwrite  = cmd_q.write;
  assign pwdata  = cmd_q.wdata;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Bench for apb_bus_arbiter: directed latency/arbitration cases plus randomized traffic vs a transaction-level model.
module tb_apb_bus_arbiter;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 16;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        f_req, d_req, d_write, pready;
  logic [15:0] f_addr, d_addr, d_wdata, prdata;

  logic        f_done, d_done, err, busy, psel, penable, pwrite;
  logic [15:0] f_rdata, d_rdata, paddr, pwdata;
  logic [1:0]  gnt;

  logic        q_f_done, q_d_done, q_err, q_busy, q_psel, q_penable, q_pwrite;
  logic [15:0] q_f_rdata, q_d_rdata, q_paddr, q_pwdata;
  logic [1:0]  q_gnt;

  apb_bus_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(TO)) u_rr (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err), .gnt(gnt), .busy(busy),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  apb_bus_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYCLES(TO)) u_prio (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(q_f_done), .f_rdata(q_f_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(q_d_done), .d_rdata(q_d_rdata), .err(q_err), .gnt(q_gnt), .busy(q_busy),
    .psel(q_psel), .penable(q_penable), .paddr(q_paddr), .pwrite(q_pwrite),
    .pwdata(q_pwdata), .prdata(prdata), .pready(pready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    f_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    pready = 1'b0; prdata = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Transaction-level reference state
  logic [15:0] ref_mem [16];
  logic [15:0] smem [16];
  logic        m_last_d;
  logic [15:0] m_f_rd, m_d_rd;
  logic        pv_psel, pv_pen, pv_rdy, pv_freq, pv_dreq, pv_fdone, pv_ddone;
  logic [1:0]  pv_gnt, el, exp_g;
  logic        exp_fd, exp_dd;
  int          f_gap, d_gap, wait_left;

  initial begin
    do_reset();
    chk_eq("rst_ctl", {23'd0, f_done, d_done, err, gnt, busy, psel, penable, pwrite}, 0);
    chk_eq("rst_data", {16'd0, f_rdata | d_rdata | paddr | pwdata}, 0);

    // Zero-wait fetch; req held through the done cycle must not re-grant
    f_req = 1'b1; f_addr = 16'h0004; pready = 1'b1; prdata = 16'hA5A5;
    tick();
    chk_eq("t1_psel", {psel, penable, busy}, 3'b101);
    chk_eq("t1_gnt", gnt, 2'b01);
    chk_eq("t1_paddr", paddr, 16'h0004);
    chk_eq("t1_pw", {pwrite, pwdata}, 0);
    tick();
    chk_eq("t1_pen", {psel, penable, f_done}, 3'b110);
    tick();
    chk_eq("t1_done", {f_done, d_done, err}, 3'b100);
    chk_eq("t1_rdata", f_rdata, 16'hA5A5);
    chk_eq("t1_idle", {psel, penable, busy, gnt}, 0);
    tick();
    chk_eq("t1_mask", {psel, f_done}, 2'b00);
    chk_eq("t1_hold", f_rdata, 16'hA5A5);
    f_req = 1'b0;

    // Data write with three wait states
    do_reset();
    d_req = 1'b1; d_write = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
    pready = 1'b0; prdata = 16'hBEEF;
    tick();
    chk_eq("t2_gnt", {gnt, psel, penable}, 4'b1010);
    chk_eq("t2_addr", paddr, 16'h0040);
    chk_eq("t2_wr", {pwrite, pwdata}, 17'h11234);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("t2_wait", {d_done, psel, penable}, 3'b011);
      chk_eq("t2_stable", {paddr, pwdata}, 32'h0040_1234);
    end
    pready = 1'b1;
    tick();
    chk_eq("t2_done", {d_done, err, pwrite}, 3'b101);
    chk_eq("t2_rdata", d_rdata, 16'h0000);
    d_req = 1'b0; pready = 1'b0;

    // Both requesting continuously: round-robin vs data-first
    do_reset();
    f_req = 1'b1; d_req = 1'b1; d_write = 1'b0; f_addr = 16'h0008; d_addr = 16'h000C;
    pready = 1'b1; prdata = 16'h0F0F;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_eq("t3_rr_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk_eq("t3_pr_gnt", q_gnt, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      tick();
      chk_eq("t3_rr_done", {d_done, f_done}, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    f_req = 1'b0; d_req = 1'b0;

    // D arrives while F is in ACCESS
    do_reset();
    f_req = 1'b1; f_addr = 16'h0010; pready = 1'b0;
    tick();
    tick();
    d_req = 1'b1; d_write = 1'b0; d_addr = 16'h0080;
    tick();
    chk_eq("t4_fhold", {gnt, psel, penable}, 4'b0111);
    pready = 1'b1; prdata = 16'h1111;
    tick();
    chk_eq("t4_fdone", {f_done, d_done, psel}, 3'b100);
    chk_eq("t4_frd", f_rdata, 16'h1111);
    prdata = 16'h2222;
    tick();
    chk_eq("t4_dsetup", {gnt, psel, penable}, 4'b1010);
    chk_eq("t4_daddr", paddr, 16'h0080);
    f_req = 1'b0;
    tick();
    tick();
    chk_eq("t4_ddone", {d_done, f_done}, 2'b10);
    chk_eq("t4_rd", {d_rdata, f_rdata}, 32'h2222_1111);
    d_req = 1'b0;

    // Reset during ACCESS loses the transfer
    do_reset();
    f_req = 1'b1; f_addr = 16'h0020; pready = 1'b0; prdata = 16'h3333;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_eq("t5_ctl", {23'd0, f_done, d_done, err, gnt, busy, psel, penable, pwrite}, 0);
    chk_eq("t5_data", {16'd0, f_rdata | d_rdata | paddr | pwdata}, 0);
    reset = 1'b0; f_req = 1'b0; pready = 1'b1;
    tick();
    chk_eq("t5_nodone", {f_done, psel}, 2'b00);

    // Randomized traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 16; i++) begin
      smem[i]    = 16'($urandom);
      ref_mem[i] = smem[i];
    end
    m_last_d = 1'b1; m_f_rd = '0; m_d_rd = '0;
    f_gap = 0; d_gap = 0; wait_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      pv_psel = psel; pv_pen = penable; pv_rdy = pready; pv_gnt = gnt;
      pv_freq = f_req; pv_dreq = d_req; pv_fdone = f_done; pv_ddone = d_done;
      tick();
      exp_fd = 1'b0; exp_dd = 1'b0;
      if (pv_psel && pv_pen && pv_rdy) begin
        exp_fd   = pv_gnt[0];
        exp_dd   = pv_gnt[1];
        m_last_d = pv_gnt[1];
        if (pv_gnt[0])     m_f_rd = ref_mem[f_addr[3:0]];
        else if (!d_write) m_d_rd = ref_mem[d_addr[3:0]];
        else               ref_mem[d_addr[3:0]] = d_wdata;
        chk_eq("r_release", {psel, penable, gnt}, 0);
      end else if (pv_psel) begin
        chk_eq("r_hold", {psel, penable, gnt}, {2'b11, pv_gnt});
      end else begin
        el = {pv_dreq & ~pv_ddone, pv_freq & ~pv_fdone};
        if (el == 2'b11) exp_g = m_last_d ? 2'b01 : 2'b10;
        else             exp_g = el;
        chk_eq("r_grant", {psel, penable, gnt}, {|exp_g, 1'b0, exp_g});
        if (exp_g == 2'b01) begin
          chk_eq("r_faddr", paddr, f_addr);
          chk_eq("r_fpw", {pwrite, pwdata}, 0);
        end else if (exp_g == 2'b10) begin
          chk_eq("r_daddr", paddr, d_addr);
          chk_eq("r_dpw", {pwrite, pwdata}, {d_write, d_wdata});
        end
      end
      chk_eq("r_done", {err, d_done, f_done}, {1'b0, exp_dd, exp_fd});
      chk_eq("r_rdata", {f_rdata, d_rdata}, {m_f_rd, m_d_rd});

      if (f_done) begin f_req = 1'b0; f_gap = $urandom_range(0, 3); end
      if (!f_req) begin
        if (f_gap == 0) begin f_req = 1'b1; f_addr = 16'($urandom); end
        else f_gap--;
      end
      if (d_done) begin d_req = 1'b0; d_gap = $urandom_range(0, 3); end
      if (!d_req) begin
        if (d_gap == 0) begin
          d_req = 1'b1; d_addr = 16'($urandom);
          d_write = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
        end else d_gap--;
      end
      if (psel && penable) begin
        if (wait_left == 0) begin
          pready = 1'b1;
          if (pwrite) begin
            smem[paddr[3:0]] = pwdata;
            prdata = 16'($urandom);
          end else begin
            prdata = smem[paddr[3:0]];
          end
        end else begin
          pready = 1'b0; prdata = 16'($urandom); wait_left--;
        end
      end else begin
        pready = 1'($urandom_range(0, 1)); prdata = 16'($urandom);
        wait_left = $urandom_range(0, 2);
      end
    end

`ifdef APB_TIMEOUT_EN
    // Stuck slave: abort after TO ACCESS cycles with err and cleared rdata
    do_reset();
    f_req = 1'b1; f_addr = 16'h0030; pready = 1'b1; prdata = 16'h7777;
    tick();
    tick();
    tick();
    chk_eq("to_pre", f_rdata, 16'h7777);
    pready = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("to_wait", {f_done, err, psel, penable}, 4'b0011);
    end
    tick();
    chk_eq("to_abort", {f_done, err}, 2'b11);
    chk_eq("to_rdata", f_rdata, 16'h0000);
    chk_eq("to_idle", {psel, penable, busy, gnt}, 0);
    f_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
